// File: rtl/count_enable_gen.sv
// Periodic enable-pulse generator for a downstream counter.
// Runs continuously or for a fixed burst of pulses.
module count_enable_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] divisor,
    input  logic [DIV_W-1:0] burst_len,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] pulses_left
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] len_q;
    logic [DIV_W-1:0] div_cnt;
    logic             accept;
    logic             hit;
    logic             last;

    assign hit = (div_cnt == div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        enable   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                // stop takes priority over a simultaneous start
                if (start && !stop) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                enable = hit && !stop;
                last   = enable && (len_q != '0)
                         && (pulses_left == DIV_W'(1));
                if (stop) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            len_q       <= '0;
            div_cnt     <= '0;
            pulses_left <= '0;
        end else if (accept) begin
            div_q       <= divisor;
            len_q       <= burst_len;
            div_cnt     <= '0;
            pulses_left <= burst_len;
        end else if (busy) begin
            if (stop) begin
                div_cnt     <= '0;
                pulses_left <= '0;
            end else begin
                div_cnt <= hit ? '0 : div_cnt + DIV_W'(1);
                if (enable && (len_q != '0)) begin
                    pulses_left <= pulses_left - DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/count_enable_gen.md
COUNT_ENABLE_GEN -- requirements
Module: count_enable_gen

Interface
REQ-001 The block SHALL have one parameter: DIV_W, default 8, the width of the divisor, the burst length and the internal counters.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin generating enable pulses; sampled in IDLE only.
REQ-005 stop  input  1  abort request; sampled in RUN.
REQ-006 divisor  input  DIV_W  the pulse period is divisor+1 cycles; latched when start is accepted.
REQ-007 burst_len  input  DIV_W  number of pulses to generate; 0 means continuous; latched when start is accepted.
REQ-008 enable  output  1  single-cycle pulse driving the downstream counter's enable input.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when a burst completes.
REQ-011 pulses_left  output  DIV_W  pulses still to be generated in burst mode; 0 in continuous mode and in IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE: when start=1 and stop=0 at a clock edge, the block SHALL latch divisor into div_q and burst_len into len_q, clear div_cnt, set pulses_left to burst_len, and enter RUN.
REQ-014 IDLE: when start=1 and stop=1 in the same cycle, stop SHALL win and the block SHALL remain in IDLE.
REQ-015 RUN: div_cnt SHALL increment each cycle, and SHALL wrap to 0 on the cycle where div_cnt==div_q.
REQ-016 enable SHALL equal (state==RUN) and (div_cnt==div_q) and not stop.
REQ-017 This is a combinational decode of registered state gated by stop; the first pulse occurs in RUN cycle div_q, counted from 0 as the first RUN cycle.
REQ-018 divisor=0 SHALL produce enable high on every RUN cycle.
REQ-019 divisor=2^DIV_W-1 SHALL produce one pulse every 2^DIV_W cycles, with no overflow beyond the wrap.
REQ-020 Burst mode (len_q!=0): each enable pulse SHALL decrement pulses_left.
REQ-021 Burst mode: a pulse issued while pulses_left==1 SHALL move the FSM to DONE at the next edge, with pulses_left=0.
REQ-022 Continuous mode (len_q==0): RUN SHALL persist until stop, and pulses_left SHALL stay 0.
REQ-023 stop=1 in RUN SHALL suppress enable in that cycle and SHALL move the FSM to IDLE at the next edge.
REQ-024 After a stop, done SHALL NOT assert and pulses_left SHALL clear to 0.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally; start during DONE SHALL be ignored.
REQ-026 start in RUN SHALL be ignored, and changes to divisor or burst_len in RUN SHALL have no effect.
REQ-027 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, div_cnt=0, div_q=0, len_q=0, pulses_left=0, enable=0, busy=0, done=0.
REQ-029 Reset asserted mid-RUN SHALL drop enable and busy immediately, with no done pulse.
REQ-030 The first start is accepted on the first rising edge after rst deasserts.

Verification
REQ-031 The bench SHALL pair the block with the 4-bit counter (enable to enable, shared clk/rst) and cover at least the scenarios REQ-032 to REQ-036.
REQ-032 divisor=0, burst_len=3, start pulse: enable high for 3 consecutive cycles; done high 1 cycle after the last pulse; busy low afterwards; counter count=4'b0011.
REQ-033 divisor=3, burst_len=2: pulses in RUN cycles 3 and 7; pulses_left goes 2->1->0; done in RUN-relative cycle 8; count=2.
REQ-034 divisor=0, burst_len=0 for 16 cycles, then stop: 16 pulses, counter wraps to 4'b0000; no enable in the stop cycle; no done; busy low next cycle.
REQ-035 start and stop together in IDLE: busy stays 0 and enable stays 0; start alone one cycle later is accepted.
REQ-036 rst asserted mid-burst (divisor=1, burst_len=5, after 2 pulses): all outputs 0 immediately; counter=0; after release, a new start runs a full 5-pulse burst.
